// File: rtl/oam_dma_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// oam_dma_arbiter_pkg
// Shared definitions for the OAM DMA arbiter and its engine:
//   - DMA state encoding
//   - CPU address map constants (high page base, DMA source register)
//   - echo RAM remap constants and the open-bus read value
//   - eff_page(): maps an echo RAM source page onto its work RAM image
// -----------------------------------------------------------------------------
package oam_dma_arbiter_pkg;

  typedef enum logic [1:0] {
    DMA_IDLE  = 2'd0,
    DMA_DELAY = 2'd1,
    DMA_XFER  = 2'd2
  } dma_state_e;

  localparam logic [15:0] HIGH_PAGE_BASE = 16'hFF00;
  localparam logic [15:0] DMA_REG_ADDR   = 16'hFF46;

  localparam logic [7:0]  ECHO_BASE_PAGE = 8'hE0;
  localparam logic [7:0]  ECHO_OFFSET    = 8'h20;

  localparam logic [7:0]  OPEN_BUS_DATA  = 8'hFF;

  // Pages 0xE0 and above alias 0xC0-0xDF (echo RAM), so fetch from the image.
  function automatic logic [7:0] eff_page(input logic [7:0] src);
    return (src >= ECHO_BASE_PAGE) ? (src - ECHO_OFFSET) : src;
  endfunction

endpackage

// File: rtl/oam_dma_engine.sv
// -----------------------------------------------------------------------------
// oam_dma_engine
// Sequencer for one OAM DMA copy: IDLE -> DELAY (START_DELAY clocks) ->
// XFER (DMA_LEN clocks, one byte each) -> IDLE. A start request is taken in
// any state and restarts the sequence from index 0 with the new page.
//
// Ports:
//   clock, reset   system clock, synchronous active-high reset
//   start_i        CPU write to the DMA source register this cycle
//   page_i         source page written by the CPU
//   src_reg_o      last written source page (read back by the CPU)
//   dma_active_o   shared bus is owned by DMA this cycle
//   src_addr_o     source address of the current transfer (0 when idle)
//   oam_addr_o     OAM index of the current transfer (0 when idle)
//   oam_wr_o       a transfer happens this cycle
// -----------------------------------------------------------------------------
module oam_dma_engine #(
  parameter int DMA_LEN     = 160,
  parameter int START_DELAY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start_i,
  input  logic [7:0]  page_i,
  output logic [7:0]  src_reg_o,
  output logic        dma_active_o,
  output logic [15:0] src_addr_o,
  output logic [7:0]  oam_addr_o,
  output logic        oam_wr_o
);

  import oam_dma_arbiter_pkg::*;

  localparam int              DCNT_W    = $clog2(START_DELAY + 1);
  localparam logic [DCNT_W-1:0] DCNT_INIT = DCNT_W'(START_DELAY);
  localparam logic [DCNT_W-1:0] DCNT_ONE  = DCNT_W'(1);
  localparam logic [7:0]      IDX_LAST  = 8'(DMA_LEN - 1);

  dma_state_e        state_q, state_d;
  logic [7:0]        idx_q, idx_d;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
  logic [7:0]        src_q, src_d;
  // Set when DELAY was entered by a restart from XFER: the bus stays owned.
  logic              restart_q, restart_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= DMA_IDLE;
      idx_q     <= '0;
      dcnt_q    <= '0;
      src_q     <= '0;
      restart_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      dcnt_q    <= dcnt_d;
      src_q     <= src_d;
      restart_q <= restart_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    dcnt_d    = dcnt_q;
    src_d     = src_q;
    restart_d = restart_q;

    case (state_q)
      DMA_DELAY: begin
        dcnt_d = dcnt_q - DCNT_ONE;
        if (dcnt_q == DCNT_ONE) begin
          state_d = DMA_XFER;
          idx_d   = '0;
        end
      end
      DMA_XFER: begin
        if (idx_q == IDX_LAST) begin
          state_d   = DMA_IDLE;
          idx_d     = '0;
          restart_d = 1'b0;
        end else begin
          idx_d = idx_q + 8'd1;
        end
      end
      default: begin
      end
    endcase

    // A new request overrides whatever the sequencer was about to do; the
    // byte at the current index (if any) still goes out this cycle.
    if (start_i) begin
      src_d     = page_i;
      idx_d     = '0;
      dcnt_d    = DCNT_INIT;
      state_d   = DMA_DELAY;
      restart_d = (state_q == DMA_XFER);
    end
  end

  always_comb begin
    oam_wr_o     = (state_q == DMA_XFER);
    dma_active_o = (state_q == DMA_XFER) || ((state_q == DMA_DELAY) && restart_q);
    src_addr_o   = oam_wr_o ? {eff_page(src_q), idx_q} : 16'h0000;
    oam_addr_o   = oam_wr_o ? idx_q : 8'h00;
    src_reg_o    = src_q;
  end

endmodule

// File: rtl/oam_dma_arbiter.sv
// -----------------------------------------------------------------------------
// oam_dma_arbiter
// Shares the memory bus between the CPU and the OAM DMA engine. CPU accesses
// to 0xFF00-0xFFFF always go out on the high-page port; the DMA source
// register lives here. Lower addresses reach the shared bus only while DMA
// does not own it; otherwise reads return open-bus data and writes are lost.
//
// Ports:
//   clock, reset            system clock, synchronous active-high reset
//   cpu_addr/wdata/rd/wr    CPU bus request
//   cpu_rdata               CPU read data (combinational)
//   mem_addr/wdata/rd/wr    shared memory bus, mem_rdata same-cycle return
//   hi_addr/wdata/rd/wr     high-page (IO/HRAM) port, hi_rdata return
//   oam_addr/wdata/wr       OAM write port fed by DMA
//   dma_active              shared bus owned by DMA
// -----------------------------------------------------------------------------
module oam_dma_arbiter #(
  parameter int          DMA_LEN      = 160,
  parameter int          START_DELAY  = 1,
  parameter logic [15:0] DMA_REG_ADDR = 16'hFF46
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  output logic [7:0]  cpu_rdata,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  hi_addr,
  output logic [7:0]  hi_wdata,
  output logic        hi_rd,
  output logic        hi_wr,
  input  logic [7:0]  hi_rdata,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_wdata,
  output logic        oam_wr,
  output logic        dma_active
);

  import oam_dma_arbiter_pkg::*;

  logic        cpu_rd_eff;
  logic        is_dma_reg;
  logic        is_high;
  logic        is_low;
  logic        dma_start;
  logic [7:0]  src_reg;
  logic [15:0] dma_src_addr;
  logic [7:0]  dma_oam_addr;
  logic        dma_oam_wr;

  // Read and write together is illegal; treat it as a write.
  assign cpu_rd_eff = cpu_rd && !cpu_wr;
  assign is_dma_reg = (cpu_addr == DMA_REG_ADDR);
  assign is_high    = (cpu_addr >= HIGH_PAGE_BASE) && !is_dma_reg;
  assign is_low     = (cpu_addr < HIGH_PAGE_BASE);
  assign dma_start  = cpu_wr && is_dma_reg;

  oam_dma_engine #(
    .DMA_LEN     (DMA_LEN),
    .START_DELAY (START_DELAY)
  ) u_engine (
    .clock        (clock),
    .reset        (reset),
    .start_i      (dma_start),
    .page_i       (cpu_wdata),
    .src_reg_o    (src_reg),
    .dma_active_o (dma_active),
    .src_addr_o   (dma_src_addr),
    .oam_addr_o   (dma_oam_addr),
    .oam_wr_o     (dma_oam_wr)
  );

  always_comb begin
    mem_addr  = 16'h0000;
    mem_wdata = 8'h00;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    hi_addr   = 8'h00;
    hi_wdata  = 8'h00;
    hi_rd     = 1'b0;
    hi_wr     = 1'b0;
    cpu_rdata = 8'h00;

    oam_addr  = dma_oam_addr;
    oam_wr    = dma_oam_wr;
    oam_wdata = dma_oam_wr ? mem_rdata : 8'h00;

    // Shared bus: DMA owns it while active (idle during a restart delay),
    // otherwise it carries low-page CPU requests only.
    if (dma_active) begin
      if (dma_oam_wr) begin
        mem_addr = dma_src_addr;
        mem_rd   = 1'b1;
      end
    end else if (is_low && (cpu_rd_eff || cpu_wr)) begin
      mem_addr  = cpu_addr;
      mem_rd    = cpu_rd_eff;
      mem_wr    = cpu_wr;
      mem_wdata = cpu_wr ? cpu_wdata : 8'h00;
    end

    if (is_high && (cpu_rd_eff || cpu_wr)) begin
      hi_addr  = cpu_addr[7:0];
      hi_rd    = cpu_rd_eff;
      hi_wr    = cpu_wr;
      hi_wdata = cpu_wr ? cpu_wdata : 8'h00;
    end

    if (cpu_rd_eff) begin
      if (is_dma_reg)      cpu_rdata = src_reg;
      else if (is_high)    cpu_rdata = hi_rdata;
      else if (dma_active) cpu_rdata = OPEN_BUS_DATA;
      else                 cpu_rdata = mem_rdata;
    end
  end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// -----------------------------------------------------------------------------
// tb_oam_dma_arbiter
// Directed bench for oam_dma_arbiter. A byte-addressed memory model answers
// the shared bus (pattern data unless written), the high-page port returns a
// fixed byte. A second instance with START_DELAY=3 checks the start latency.
// -----------------------------------------------------------------------------
module tb_oam_dma_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_rd, cpu_wr;
  logic [7:0]  cpu_rdata;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_rd, mem_wr;
  logic [7:0]  hi_addr, hi_wdata, hi_rdata;
  logic        hi_rd, hi_wr;
  logic [7:0]  oam_addr, oam_wdata;
  logic        oam_wr, dma_active;

  // second instance, START_DELAY=3
  logic [15:0] cpu3_addr;
  logic [7:0]  cpu3_wdata;
  logic        cpu3_rd, cpu3_wr;
  logic [7:0]  cpu3_rdata;
  logic [15:0] mem3_addr;
  logic [7:0]  mem3_wdata, mem3_rdata;
  logic        mem3_rd, mem3_wr;
  logic [7:0]  hi3_addr, hi3_wdata;
  logic        hi3_rd, hi3_wr;
  logic [7:0]  oam3_addr, oam3_wdata;
  logic        oam3_wr, dma3_active;

  int assert_count = 0;
  int fail_count   = 0;

  always #5 clock = ~clock;

  localparam logic [7:0] HI_DATA = 8'h3C;
  assign hi_rdata = HI_DATA;

  oam_dma_arbiter u_dut (
    .clock(clock), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .cpu_rdata(cpu_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata),
    .hi_addr(hi_addr), .hi_wdata(hi_wdata), .hi_rd(hi_rd), .hi_wr(hi_wr),
    .hi_rdata(hi_rdata),
    .oam_addr(oam_addr), .oam_wdata(oam_wdata), .oam_wr(oam_wr),
    .dma_active(dma_active)
  );

  oam_dma_arbiter #(.START_DELAY(3)) u_dut3 (
    .clock(clock), .reset(reset),
    .cpu_addr(cpu3_addr), .cpu_wdata(cpu3_wdata), .cpu_rd(cpu3_rd), .cpu_wr(cpu3_wr),
    .cpu_rdata(cpu3_rdata),
    .mem_addr(mem3_addr), .mem_wdata(mem3_wdata), .mem_rd(mem3_rd), .mem_wr(mem3_wr),
    .mem_rdata(mem3_rdata),
    .hi_addr(hi3_addr), .hi_wdata(hi3_wdata), .hi_rd(hi3_rd), .hi_wr(hi3_wr),
    .hi_rdata(hi_rdata),
    .oam_addr(oam3_addr), .oam_wdata(oam3_wdata), .oam_wr(oam3_wr),
    .dma_active(dma3_active)
  );

  // ---------------- memory model ----------------
  bit         wflag [65536];
  logic [7:0] wbyte [65536];

  function automatic logic [7:0] pat(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] mem_peek(input logic [15:0] a);
    return wflag[a] ? wbyte[a] : pat(a);
  endfunction

  always_comb begin
    mem_rdata  = mem_rd  ? mem_peek(mem_addr) : 8'h00;
    mem3_rdata = mem3_rd ? pat(mem3_addr)     : 8'h00;
  end

  always @(posedge clock) begin
    if (mem_wr) begin
      wflag[mem_addr] <= 1'b1;
      wbyte[mem_addr] <= mem_wdata;
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [15:0] actual, input logic [15:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic cpu_idle();
    cpu_addr  = 16'h0000;
    cpu_wdata = 8'h00;
    cpu_rd    = 1'b0;
    cpu_wr    = 1'b0;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    cpu_addr  = a;
    cpu_wdata = d;
    cpu_rd    = 1'b0;
    cpu_wr    = 1'b1;
  endtask

  task automatic cpu_read(input logic [15:0] a);
    cpu_addr  = a;
    cpu_wdata = 8'h00;
    cpu_rd    = 1'b1;
    cpu_wr    = 1'b0;
  endtask

  // Checks one transfer cycle; call after the negedge of that cycle.
  task automatic check_xfer(input logic [15:0] base, input int k);
    logic [15:0] a;
    a = base + 16'(k);
    check("xfer_oam_wr",    16'(oam_wr),     16'h0001);
    check("xfer_active",    16'(dma_active), 16'h0001);
    check("xfer_mem_rd",    16'(mem_rd),     16'h0001);
    check("xfer_mem_wr",    16'(mem_wr),     16'h0000);
    check("xfer_mem_addr",  mem_addr,        a);
    check("xfer_oam_addr",  16'(oam_addr),   16'(k));
    check("xfer_oam_wdata", 16'(oam_wdata),  16'(pat(a)));
  endtask

  // Runs transfer cycles first..last; entered at posedge+1 of cycle 'first'.
  task automatic run_xfer(input logic [15:0] base, input int first, input int last);
    for (int k = first; k <= last; k++) begin
      @(negedge clock);
      check_xfer(base, k);
      next_cycle();
    end
  endtask

  // Start a copy and step through a one-clock initial delay.
  task automatic start_dma(input logic [7:0] page);
    cpu_write(16'hFF46, page);
    @(negedge clock);
    check("start_hi_wr",  16'(hi_wr),  16'h0000);
    check("start_mem_wr", 16'(mem_wr), 16'h0000);
    next_cycle();
    cpu_idle();
    @(negedge clock);
    check("delay_active", 16'(dma_active), 16'h0000);
    check("delay_oam_wr", 16'(oam_wr),     16'h0000);
    next_cycle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    cpu_idle();
    cpu3_addr = 16'h0000; cpu3_wdata = 8'h00; cpu3_rd = 1'b0; cpu3_wr = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    @(negedge clock);
    $display("[tb] reset state");
    check("rst_active",   16'(dma_active), 16'h0000);
    check("rst_oam_wr",   16'(oam_wr),     16'h0000);
    check("rst_oam_addr", 16'(oam_addr),   16'h0000);
    check("rst_mem_rd",   16'(mem_rd),     16'h0000);
    check("rst_mem_wr",   16'(mem_wr),     16'h0000);
    check("rst_mem_addr", mem_addr,        16'h0000);
    check("rst_hi_rd",    16'(hi_rd),      16'h0000);
    check("rst_active3",  16'(dma3_active), 16'h0000);
    next_cycle();
    reset = 1'b0;

    // Copy from page C1 with CPU traffic mixed in.
    $display("[tb] dma page C1 with cpu traffic");
    start_dma(8'hC1);
    for (int k = 0; k < 160; k++) begin
      cpu_idle();
      if (k == 10) cpu_read(16'h8000);
      if (k == 20) cpu_write(16'hC000, 8'h55);
      if (k == 30) cpu_read(16'hFF85);
      @(negedge clock);
      check_xfer(16'hC100, k);
      if (k == 10) check("blocked_rdata", 16'(cpu_rdata), 16'h00FF);
      if (k == 30) begin
        check("hi_rd_in_dma",    16'(hi_rd),     16'h0001);
        check("hi_addr_in_dma",  16'(hi_addr),   16'h0085);
        check("hi_rdata_in_dma", 16'(cpu_rdata), 16'(HI_DATA));
      end
      next_cycle();
    end
    cpu_idle();
    @(negedge clock);
    check("end_active", 16'(dma_active), 16'h0000);
    check("end_oam_wr", 16'(oam_wr),     16'h0000);
    check("end_mem_rd", 16'(mem_rd),     16'h0000);
    check("dropped_write", 16'(mem_peek(16'hC000)), 16'(pat(16'hC000)));
    next_cycle();

    // Idle CPU access to low memory and the high page.
    $display("[tb] cpu write/read C005 while idle");
    cpu_write(16'hC005, 8'h77);
    @(negedge clock);
    check("idle_mem_wr",    16'(mem_wr),    16'h0001);
    check("idle_mem_addr",  mem_addr,       16'hC005);
    check("idle_mem_wdata", 16'(mem_wdata), 16'h0077);
    check("idle_hi_wr",     16'(hi_wr),     16'h0000);
    next_cycle();
    cpu_read(16'hC005);
    @(negedge clock);
    check("idle_mem_rd",    16'(mem_rd),    16'h0001);
    check("idle_rdata",     16'(cpu_rdata), 16'h0077);
    next_cycle();
    $display("[tb] cpu rd+wr FF80");
    cpu_write(16'hFF80, 8'hA5);
    cpu_rd = 1'b1;
    @(negedge clock);
    check("rdwr_hi_wr",    16'(hi_wr),    16'h0001);
    check("rdwr_hi_rd",    16'(hi_rd),    16'h0000);
    check("rdwr_hi_wdata", 16'(hi_wdata), 16'h00A5);
    check("rdwr_hi_addr",  16'(hi_addr),  16'h0080);
    next_cycle();
    cpu_idle();

    // Echo page E2 maps to C2; read back the register during the delay.
    $display("[tb] dma page E2 (echo)");
    cpu_write(16'hFF46, 8'hE2);
    @(negedge clock);
    next_cycle();
    cpu_read(16'hFF46);
    @(negedge clock);
    check("ff46_rdata",  16'(cpu_rdata),  16'h00E2);
    check("ff46_hi_rd",  16'(hi_rd),      16'h0000);
    check("echo_delay",  16'(dma_active), 16'h0000);
    next_cycle();
    cpu_idle();
    run_xfer(16'hC200, 0, 159);
    @(negedge clock);
    check("echo_end", 16'(dma_active), 16'h0000);
    next_cycle();

    // Restart at index 0x40 with page D0.
    $display("[tb] restart at idx 40 with page D0");
    start_dma(8'hC1);
    run_xfer(16'hC100, 0, 'h3F);
    cpu_write(16'hFF46, 8'hD0);
    @(negedge clock);
    check_xfer(16'hC100, 'h40);
    next_cycle();
    cpu_read(16'h8000);
    @(negedge clock);
    check("restart_active", 16'(dma_active), 16'h0001);
    check("restart_oam_wr", 16'(oam_wr),     16'h0000);
    check("restart_mem_rd", 16'(mem_rd),     16'h0000);
    check("restart_rdata",  16'(cpu_rdata),  16'h00FF);
    next_cycle();
    cpu_idle();
    run_xfer(16'hD000, 0, 159);
    @(negedge clock);
    check("restart_end", 16'(dma_active), 16'h0000);
    next_cycle();

    // Reset in the middle of a copy.
    $display("[tb] reset at idx 10");
    start_dma(8'hC1);
    run_xfer(16'hC100, 0, 'h0F);
    reset = 1'b1;
    @(negedge clock);
    check_xfer(16'hC100, 'h10);
    next_cycle();
    @(negedge clock);
    check("mid_rst_oam_wr", 16'(oam_wr),     16'h0000);
    check("mid_rst_active", 16'(dma_active), 16'h0000);
    next_cycle();
    reset = 1'b0;
    cpu_read(16'h8000);
    @(negedge clock);
    check("post_rst_mem_rd",   16'(mem_rd),    16'h0001);
    check("post_rst_mem_addr", mem_addr,       16'h8000);
    check("post_rst_rdata",    16'(cpu_rdata), 16'h00DA);
    next_cycle();
    cpu_read(16'hFF46);
    @(negedge clock);
    check("post_rst_src", 16'(cpu_rdata), 16'h0000);
    next_cycle();
    cpu_idle();

    // START_DELAY=3 instance: first transfer 4 clocks after the write.
    $display("[tb] start delay 3, page 80");
    cpu3_addr = 16'hFF46; cpu3_wdata = 8'h80; cpu3_wr = 1'b1;
    @(negedge clock);
    check("sd3_w_active", 16'(dma3_active), 16'h0000);
    next_cycle();
    cpu3_addr = 16'h0000; cpu3_wdata = 8'h00; cpu3_wr = 1'b0;
    for (int j = 1; j <= 3; j++) begin
      @(negedge clock);
      check("sd3_delay_active", 16'(dma3_active), 16'h0000);
      check("sd3_delay_oam_wr", 16'(oam3_wr),     16'h0000);
      next_cycle();
    end
    @(negedge clock);
    check("sd3_first_oam_wr",   16'(oam3_wr),     16'h0001);
    check("sd3_first_active",   16'(dma3_active), 16'h0001);
    check("sd3_first_oam_addr", 16'(oam3_addr),   16'h0000);
    check("sd3_first_mem_addr", mem3_addr,        16'h8000);
    check("sd3_first_wdata",    16'(oam3_wdata),  16'(pat(16'h8000)));
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
